dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 32, data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 256, memory size in DWIDTH words.
REQ-003 The block SHALL have parameter WAIT_CYCLES, default 1, wait states inserted before acknowledge (legal range 0..15).
REQ-004 The block SHALL have port dm_clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port dm_rst, input, 1, reset; it is synchronous and active-high.
REQ-006 The block SHALL have port dm_i_req, input, 1, request valid from the memory stage.
REQ-007 The block SHALL have port dm_i_we, input, 1, 1 = store, 0 = load.
REQ-008 The block SHALL have port dm_i_addr, input, 32, byte address.
REQ-009 The block SHALL have port dm_i_data, input, DWIDTH, store data.
REQ-010 The block SHALL have port dm_i_sel, input, DWIDTH/8, byte-lane enables for stores.
REQ-011 The block SHALL have port dm_o_stall, output, 1, busy; requests are not accepted while it is high.
REQ-012 The block SHALL have port dm_o_ack, output, 1, one-cycle completion pulse.
REQ-013 The block SHALL have port dm_o_data, output, DWIDTH, load data.
REQ-014 The block SHALL have port dm_o_err, output, 1, error flag, valid with dm_o_ack.

Function
REQ-015 FSM states SHALL be IDLE, WAIT and ACK; dm_o_stall SHALL be 1 exactly when the state is not IDLE.
REQ-016 A request SHALL be accepted in cycle N when dm_i_req=1 and the state is IDLE; at that edge dm_i_we, dm_i_addr, dm_i_data and dm_i_sel SHALL be latched.
REQ-017 After acceptance, the FSM SHALL go to WAIT if WAIT_CYCLES>0, otherwise to ACK; WAIT SHALL last exactly WAIT_CYCLES cycles, counted by a down-counter, then go to ACK.
REQ-018 dm_o_ack SHALL be 1 only in cycle N+1+WAIT_CYCLES, for exactly one cycle; ACK SHALL always go to IDLE next.
REQ-019 A store SHALL write only the byte lanes whose dm_i_sel bit is set, committed at the edge that ends the ACK cycle; the other lanes SHALL be unchanged.
REQ-020 A load SHALL drive the full addressed word on dm_o_data during the ACK cycle, and dm_o_data SHALL hold until the next load ack; a store ack SHALL leave dm_o_data unchanged.
REQ-021 Word index SHALL be dm_i_addr[31:2]; a load that follows a store to the same word SHALL return the stored data.
REQ-022 dm_i_req while dm_o_stall=1 SHALL be ignored; deasserting dm_i_req during WAIT SHALL NOT cancel the pending access.
REQ-023 A store with dm_i_sel all zero SHALL complete with ack and SHALL leave memory unchanged.

Reset
REQ-024 While dm_rst=1 at a clock edge: state SHALL become IDLE, counter 0, dm_o_stall=0, dm_o_ack=0, dm_o_err=0, dm_o_data=0.
REQ-025 Reset during WAIT or ACK SHALL abort the access, no ack SHALL be issued, and a pending store SHALL be discarded.
REQ-026 Memory array contents SHALL NOT be cleared by reset.

Configuration
REQ-027 With macro DMEM_ERR_CHECK_EN defined: an access with dm_i_addr[1:0]!=0 or word index >= DEPTH SHALL ack with dm_o_err=1, SHALL perform no write, and dm_o_data SHALL be 0 in that ack cycle.
REQ-028 Without DMEM_ERR_CHECK_EN: dm_o_err SHALL be tied 0, dm_i_addr[1:0] SHALL be ignored, and word index SHALL wrap modulo DEPTH.

Verification (DEPTH=256, WAIT_CYCLES=2)
REQ-029 Store addr 0x10, data 0xDEADBEEF, sel 4'hF accepted cycle 5 -> ack only in cycle 8, stall high cycles 6-8; then load 0x10 -> dm_o_data=0xDEADBEEF at ack.
REQ-030 Store 0x10, data 0x000000AA, sel 4'b0001 over 0xDEADBEEF -> subsequent load returns 0xDEADBEAA.
REQ-031 Second dm_i_req held high during cycles 6-8 -> not accepted until cycle 9; exactly one ack per accepted request.
REQ-032 dm_rst pulsed in the WAIT cycle of a store to 0x20 -> no ack; later load of 0x20 returns its prior value; outputs read 0 after reset.
REQ-033 With DMEM_ERR_CHECK_EN: load 0x13 -> ack with dm_o_err=1, dm_o_data=0; store to 0x400 -> err=1, memory unchanged. Without it: load 0x400 returns word 0.
REQ-034 WAIT_CYCLES=0: request accepted cycle 3 -> ack in cycle 4; back-to-back accepts every 2 cycles.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: one access at a time, WAIT_CYCLES wait states, byte-lane stores.
// Define DMEM_ERR_CHECK_EN to flag misaligned or out-of-range accesses with dm_o_err.
module dmem_responder #(
  parameter int DWIDTH      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  dm_clk,
  input  logic                  dm_rst,
  input  logic                  dm_i_req,
  input  logic                  dm_i_we,
  input  logic [31:0]           dm_i_addr,
  input  logic [DWIDTH-1:0]     dm_i_data,
  input  logic [DWIDTH/8-1:0]   dm_i_sel,
  output logic                  dm_o_stall,
  output logic                  dm_o_ack,
  output logic [DWIDTH-1:0]     dm_o_data,
  output logic                  dm_o_err
);

  localparam int NSEL = DWIDTH / 8;
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic [NSEL-1:0]   sel_q, sel_d;
  logic [DWIDTH-1:0] rdata_q, rdata_d;
  logic              ack_q, stall_q, oerr_q;

  logic [DWIDTH-1:0] mem_q [DEPTH];

  logic [29:0]       word_s;
  logic [AW-1:0]     req_idx_s;
  logic              req_err_s;

  assign word_s    = dm_i_addr[31:2];
  assign req_idx_s = AW'(word_s % 30'(DEPTH));

`ifdef DMEM_ERR_CHECK_EN
  assign req_err_s = (dm_i_addr[1:0] != 2'b00) || (word_s >= 30'(DEPTH));
`else
  logic unused_addr_s;
  assign unused_addr_s = ^dm_i_addr[1:0];
  assign req_err_s     = 1'b0;
`endif

  // Next-state: capture the request in IDLE, count wait states, leave ACK after one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    err_d   = err_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    case (state_q)
      S_IDLE: begin
        if (dm_i_req) begin
          we_d    = dm_i_we;
          err_d   = req_err_s;
          idx_d   = req_idx_s;
          wdata_d = dm_i_data;
          sel_d   = dm_i_sel;
          cnt_d   = WAIT_LOAD;
          state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_ACK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Load data is sampled on entry to ACK; stores never disturb the last returned word.
  always_comb begin
    rdata_d = rdata_q;
    if ((state_d == S_ACK) && (state_q != S_ACK)) begin
      if (err_d) begin
        rdata_d = '0;
      end else if (!we_d) begin
        rdata_d = mem_q[idx_d];
      end else begin
        rdata_d = rdata_q;
      end
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge dm_clk) begin
    if (dm_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      stall_q <= 1'b0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      ack_q   <= (state_d == S_ACK);
      stall_q <= (state_d != S_IDLE);
      oerr_q  <= (state_d == S_ACK) && err_d;
    end
  end

  // Store commit at the edge closing ACK; reset in the same cycle drops it.
  always_ff @(posedge dm_clk) begin
    if (!dm_rst && (state_q == S_ACK) && we_q && !err_q) begin
      for (int b = 0; b < NSEL; b++) begin
        if (sel_q[b]) begin
          mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign dm_o_stall = stall_q;
  assign dm_o_ack   = ack_q;
  assign dm_o_data  = rdata_q;
  assign dm_o_err   = oerr_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table on a WAIT_CYCLES=2 instance,
// hand sequences for held requests, reset mid-access and a zero-wait instance.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req, we;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  sel;
  logic        stall, ack, err;

  logic        zreq, zwe;
  logic [31:0] zaddr, zwdata, zrdata;
  logic [3:0]  zsel;
  logic        zstall, zack, zerr;

  int n_vec = 0;
  int n_bad = 0;

  dmem_responder #(.DWIDTH(32), .DEPTH(256), .WAIT_CYCLES(2)) dut (
    .dm_clk(clk), .dm_rst(rst), .dm_i_req(req), .dm_i_we(we), .dm_i_addr(addr),
    .dm_i_data(wdata), .dm_i_sel(sel), .dm_o_stall(stall), .dm_o_ack(ack),
    .dm_o_data(rdata), .dm_o_err(err)
  );

  dmem_responder #(.DWIDTH(32), .DEPTH(256), .WAIT_CYCLES(0)) dut0 (
    .dm_clk(clk), .dm_rst(rst), .dm_i_req(zreq), .dm_i_we(zwe), .dm_i_addr(zaddr),
    .dm_i_data(zwdata), .dm_i_sel(zsel), .dm_o_stall(zstall), .dm_o_ack(zack),
    .dm_o_data(zrdata), .dm_o_err(zerr)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [31:0] ed, input logic ee);
    vec_t v;
    v.we = w; v.addr = a; v.data = d; v.sel = s; v.exp_data = ed; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  // One access on the WAIT_CYCLES=2 instance, called with the DUT idle just after an edge.
  task automatic access(input vec_t v, input string tag);
    int   lat;
    logic stall_gap;
    stall_gap = 1'b0;
    req = 1'b1; we = v.we; addr = v.addr; wdata = v.data; sel = v.sel;
    tick();
    req = 1'b0;
    lat = 1;
    while (ack !== 1'b1 && lat < 20) begin
      if (stall !== 1'b1) stall_gap = 1'b1;
      tick();
      lat++;
    end
    check($sformatf("%s latency", tag), 32'(lat), 32'd3);
    check($sformatf("%s stall_wait", tag), 32'(stall_gap), 32'd0);
    check($sformatf("%s stall_ack", tag), 32'(stall), 32'd1);
    check($sformatf("%s data", tag), rdata, v.exp_data);
    check($sformatf("%s err", tag), 32'(err), 32'(v.exp_err));
    tick();
    check($sformatf("%s ack_one_cycle", tag), 32'(ack), 32'd0);
    check($sformatf("%s stall_release", tag), 32'(stall), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    int   acks[$];
    int   a0, a1;
    int   nack;
    logic [31:0] zd3;
    vec_t v;

    rst = 1'b1; req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0; sel = 4'h0;
    zreq = 1'b0; zwe = 1'b0; zaddr = 32'h0; zwdata = 32'h0; zsel = 4'h0;
    repeat (3) tick();
    check("reset stall", 32'(stall), 32'd0);
    check("reset ack", 32'(ack), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset data", rdata, 32'h0);
    check("reset z_stall", 32'(zstall), 32'd0);
    rst = 1'b0;
    tick();

    add(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h00000000, 1'b0);
    add(1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0);
    add(1'b1, 32'h10, 32'h000000AA, 4'h1, 32'hDEADBEEF, 1'b0);
    add(1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADBEAA, 1'b0);
    add(1'b1, 32'h10, 32'h11223344, 4'h0, 32'hDEADBEAA, 1'b0);
    add(1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADBEAA, 1'b0);
    add(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 32'hDEADBEAA, 1'b0);
    add(1'b1, 32'h20, 32'h55667788, 4'hA, 32'hDEADBEAA, 1'b0);
    add(1'b0, 32'h20, 32'h0,        4'h0, 32'h55FE770D, 1'b0);
    add(1'b1, 32'h00, 32'h12345678, 4'hF, 32'h55FE770D, 1'b0);
    add(1'b0, 32'h00, 32'h0,        4'h0, 32'h12345678, 1'b0);
`ifdef DMEM_ERR_CHECK_EN
    add(1'b0, 32'h13,  32'h0,        4'h0, 32'h00000000, 1'b1);
    add(1'b1, 32'h400, 32'h99999999, 4'hF, 32'h00000000, 1'b1);
    add(1'b0, 32'h00,  32'h0,        4'h0, 32'h12345678, 1'b0);
`else
    add(1'b0, 32'h13,  32'h0,        4'h0, 32'hDEADBEAA, 1'b0);
    add(1'b0, 32'h400, 32'h0,        4'h0, 32'h12345678, 1'b0);
    add(1'b1, 32'h404, 32'hA5A5A5A5, 4'hF, 32'h12345678, 1'b0);
    add(1'b0, 32'h04,  32'h0,        4'h0, 32'hA5A5A5A5, 1'b0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      access(vecs[i], $sformatf("vec%0d", i));
    end

    // Request held high through a busy access: second load starts only once IDLE.
    we = 1'b0; addr = 32'h10; wdata = 32'h0; sel = 4'h0;
    for (int i = 0; i < 12; i++) begin
      req = (i <= 4);
      if (ack === 1'b1) acks.push_back(i);
      if (i == 1) check("held stall_busy", 32'(stall), 32'd1);
      if (i == 4) check("held stall_idle", 32'(stall), 32'd0);
      tick();
    end
    req = 1'b0;
    a0 = (acks.size() > 0) ? acks[0] : -1;
    a1 = (acks.size() > 1) ? acks[1] : -1;
    check("held ack_count", 32'(acks.size()), 32'd2);
    check("held first_ack", 32'(a0), 32'd3);
    check("held second_ack", 32'(a1), 32'd7);
    check("held data", rdata, 32'hDEADBEAA);

    // Reset in WAIT of a store to 0x20: access dropped, outputs cleared, memory kept.
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hFFFFFFFF; sel = 4'hF;
    tick();
    req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_wait ack", 32'(ack), 32'd0);
    check("rst_wait stall", 32'(stall), 32'd0);
    check("rst_wait err", 32'(err), 32'd0);
    check("rst_wait data", rdata, 32'h0);
    nack = 0;
    for (int i = 0; i < 6; i++) begin
      if (ack === 1'b1) nack++;
      tick();
    end
    check("rst_wait no_ack", 32'(nack), 32'd0);
    v.we = 1'b0; v.addr = 32'h20; v.data = 32'h0; v.sel = 4'h0;
    v.exp_data = 32'h55FE770D; v.exp_err = 1'b0;
    access(v, "rst_wait reload");

    // Zero wait states: store then load back-to-back, acks every other cycle.
    acks.delete();
    zd3 = 32'h0;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin
        zreq = 1'b1; zwe = 1'b1; zaddr = 32'h8; zwdata = 32'h0BADF00D; zsel = 4'hF;
      end
      if (i == 1) zwe = 1'b0;
      if (i == 3) zreq = 1'b0;
      if (zack === 1'b1) acks.push_back(i);
      if (i == 3) zd3 = zrdata;
      tick();
    end
    a0 = (acks.size() > 0) ? acks[0] : -1;
    a1 = (acks.size() > 1) ? acks[1] : -1;
    check("zero_wait ack_count", 32'(acks.size()), 32'd2);
    check("zero_wait first_ack", 32'(a0), 32'd1);
    check("zero_wait second_ack", 32'(a1), 32'd3);
    check("zero_wait data", zd3, 32'h0BADF00D);
    check("zero_wait err", 32'(zerr), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
